// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage of the pipelined RISC-V core.
//
// Owns the program counter and keeps at most one request outstanding to
// instruction memory. Each returned word is captured into the IF/ID register,
// which feeds the decoder. Branch/jump results from execute redirect the PC
// and flush any wrong-path instruction.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   StallD            hazard-unit hold of IF/ID and PC
//   BranchE, ZeroE    execute-stage branch and ALU zero flag
//   JE                execute-stage jump kind (01 JAL, 10 JALR)
//   PCE, ImmExtE      execute-stage PC and immediate (branch/JAL target)
//   ALUResultE        JALR target
//   imem_req          one-cycle request pulse, address on imem_addr (= PCF)
//   imem_rdata/valid  memory response
//   PCF               current fetch PC
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        BranchE,
  input  logic        ZeroE,
  input  logic [1:0]  JE,
  input  logic [31:0] PCE,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] ALUResultE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DROP  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] skid_q, skid_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  always_comb begin
    redirect = (BranchE & ZeroE) | (JE == 2'b01) | (JE == 2'b10);
    target   = (JE == 2'b10) ? {ALUResultE[31:1], 1'b0} : (PCE + ImmExtE);
    pc_plus4 = pc_q + 32'd4;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    skid_d  = skid_q;

    if (redirect) begin
      // Flush beats stall: the IF/ID content is wrong-path regardless.
      pc_d    = target;
      instr_d = NOP;
      pcd_d   = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
      skid_d  = NOP;
      unique case (state_q)
        // Request issued this cycle: its response is still to come.
        S_ISSUE: state_d = S_DROP;
        // Response arriving now is simply discarded; nothing left in flight.
        S_WAIT:  state_d = imem_valid ? S_ISSUE : S_DROP;
        // Keep waiting for the stale response, unless it is the one arriving
        // now -- staying in DROP then would wait for a word that never comes.
        S_DROP:  state_d = imem_valid ? S_ISSUE : S_DROP;
        default: state_d = S_ISSUE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            if (!StallD) begin
              instr_d = imem_rdata;
              pcd_d   = pc_q;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
              pc_d    = pc_plus4;
              state_d = S_ISSUE;
            end else begin
              skid_d  = imem_rdata;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!StallD) begin
            instr_d = skid_q;
            pcd_d   = pc_q;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            state_d = S_ISSUE;
          end
        end
        S_DROP:  state_d = imem_valid ? S_ISSUE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end

    // Request pulse is registered: high for exactly the cycle spent in ISSUE.
    req_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pcd_q   <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      skid_q  <= NOP;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      skid_q  <= skid_d;
      req_q   <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign PCF       = pc_q;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pc4_q;
  assign ValidD    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder with configurable latency plus a
// token-level reference model. Every request becomes a token; redirects and
// reset kill all outstanding tokens; a live token's word is accepted into
// IF/ID (or parked while stalled) and advances the expected PC by 4.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, StallD, BranchE, ZeroE;
  logic [1:0]  JE;
  logic [31:0] PCE, ImmExtE, ALUResultE;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_unit dut (
    .clk(clk), .rst(rst), .StallD(StallD), .BranchE(BranchE), .ZeroE(ZeroE),
    .JE(JE), .PCE(PCE), .ImmExtE(ImmExtE), .ALUResultE(ALUResultE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc_n = 0, mem_lat = 1, req_bad = 0, accepted = 0;

  logic [31:0] q_addr[$];
  int          q_due[$];
  bit          q_kill[$];

  logic [31:0] exp_pc, exp_instr, exp_pcd, exp_pc4, held_word;
  logic        exp_valid;
  bit          held;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic idle_in();
    StallD = 0; BranchE = 0; ZeroE = 0; JE = 2'b00;
    PCE = 0; ImmExtE = 0; ALUResultE = 0;
  endtask

  task automatic accept(input logic [31:0] w);
    exp_instr = w;
    exp_pcd   = exp_pc;
    exp_pc4   = exp_pc + 32'd4;
    exp_valid = 1'b1;
    exp_pc    = exp_pc + 32'd4;
    accepted++;
  endtask

  // One clock cycle: drive the memory response, record requests, advance the
  // model with this cycle's inputs, then move to #1 after the next edge.
  task automatic cyc();
    bit          rd, live;
    logic [31:0] tgt;
    imem_valid = 1'b0; imem_rdata = 32'hDEAD_BEEF; live = 0;
    if (q_due.size() > 0 && q_due[0] == cyc_n) begin
      imem_valid = 1'b1;
      imem_rdata = mem_word(q_addr[0]);
      live = !q_kill[0];
      void'(q_addr.pop_front()); void'(q_due.pop_front()); void'(q_kill.pop_front());
    end
    if (imem_req === 1'b1) begin
      if (imem_addr !== exp_pc) req_bad++;
      foreach (q_kill[i]) if (!q_kill[i]) req_bad++;
      q_addr.push_back(imem_addr); q_due.push_back(cyc_n + mem_lat); q_kill.push_back(0);
    end
    rd  = (BranchE && ZeroE) || JE == 2'b01 || JE == 2'b10;
    tgt = (JE == 2'b10) ? (ALUResultE & ~32'd1) : (PCE + ImmExtE);
    if (rst || rd) begin
      foreach (q_kill[i]) q_kill[i] = 1;
      held = 0;
      exp_instr = NOP; exp_pcd = 0; exp_pc4 = 0; exp_valid = 0;
      exp_pc = rst ? 32'h0 : tgt;
    end else if (imem_valid && live) begin
      if (!StallD) accept(imem_rdata);
      else begin held = 1; held_word = imem_rdata; end
    end else if (held && !StallD) begin
      accept(held_word);
      held = 0;
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic test_reset();
    rst = 1; idle_in(); mem_lat = 1;
    cyc(); cyc();
    n_chk++;
    if ({PCF, imem_req, InstrD, PCD, PCPlus4D, ValidD} !== {32'h0, 1'b0, NOP, 32'h0, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL reset_values: got pcf=%h req=%b instr=%h pcd=%h pc4=%h v=%b", PCF, imem_req, InstrD, PCD, PCPlus4D, ValidD);
    end
    rst = 0;
    cyc();
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_first_req: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    end
    cyc();
    n_chk++;
    if (ValidD !== 1'b0) begin
      n_err++; $display("FAIL reset_no_early_valid: got ValidD=%b want 0", ValidD);
    end
    cyc();
    n_chk++;
    if ({ValidD, InstrD, PCD, PCPlus4D, PCF} !== {1'b1, mem_word(32'h0), 32'h0, 32'h4, 32'h4}) begin
      n_err++; $display("FAIL reset_first_instr: got v=%b instr=%h pcd=%h pc4=%h pcf=%h want 1/%h/0/4/4", ValidD, InstrD, PCD, PCPlus4D, PCF, mem_word(32'h0));
    end
  endtask

  task automatic test_straight();
    logic [31:0] prev;
    int changes = 0;
    mem_lat = 1; idle_in();
    prev = PCD;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (PCD !== prev) changes++;
      prev = PCD;
      n_chk++;
      if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== {exp_pc, exp_instr, exp_pcd, exp_pc4, exp_valid}) begin
        n_err++; $display("FAIL straight c%0d: got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b", cyc_n, PCF, InstrD, PCD, PCPlus4D, ValidD, exp_pc, exp_instr, exp_pcd, exp_pc4, exp_valid);
      end
    end
    n_chk++;
    if (changes !== 4) begin
      n_err++; $display("FAIL straight_rate: got %0d IF/ID updates in 8 cycles want 4", changes);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0;
    logic [96:0] snap;
    mem_lat = 1; idle_in();
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) cyc();
    n_chk++;
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL stall_req_timeout: got req=%b want 1", imem_req); end
    pc0 = PCF;
    snap = {InstrD, PCD, PCPlus4D, ValidD};
    StallD = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_chk++;
      if ({InstrD, PCD, PCPlus4D, ValidD, PCF} !== {snap, pc0}) begin
        n_err++; $display("FAIL stall_hold c%0d: got %h/%h/%h/%b pcf=%h want %h pcf=%h", cyc_n, InstrD, PCD, PCPlus4D, ValidD, PCF, snap, pc0);
      end
    end
    StallD = 0;
    cyc();
    n_chk++;
    if ({InstrD, PCD, PCPlus4D, ValidD, PCF} !== {mem_word(pc0), pc0, pc0 + 32'd4, 1'b1, pc0 + 32'd4}) begin
      n_err++; $display("FAIL stall_release: got %h/%h/%h/%b pcf=%h want %h/%h", InstrD, PCD, PCPlus4D, ValidD, PCF, mem_word(pc0), pc0);
    end
    cyc(); cyc();
    n_chk++;
    if ({InstrD, PCD} !== {mem_word(pc0 + 32'd4), pc0 + 32'd4}) begin
      n_err++; $display("FAIL stall_next_word: got %h/%h want %h/%h", InstrD, PCD, mem_word(pc0 + 32'd4), pc0 + 32'd4);
    end
  endtask

  task automatic test_jal();
    int waited = 0;
    idle_in();
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) cyc();
    mem_lat = 3;
    cyc();
    JE = 2'b01; PCE = 32'h100; ImmExtE = 32'hFFFF_FFF0;
    cyc();
    idle_in();
    n_chk++;
    if ({PCF, InstrD, PCD, ValidD} !== {32'hF0, NOP, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL jal_flush: got pcf=%h instr=%h pcd=%h v=%b want f0/%h/0/0", PCF, InstrD, PCD, ValidD, NOP);
    end
    mem_lat = 1;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) begin
      cyc(); waited++;
      n_chk++;
      if (ValidD !== exp_valid) begin n_err++; $display("FAIL jal_drop: got ValidD=%b want %b", ValidD, exp_valid); end
    end
    // Response to the flushed request lands two cycles after the redirect.
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hF0 || waited !== 2) begin
      n_err++; $display("FAIL jal_refetch: got req=%b addr=%h after %0d cycles want 1/f0 after 2", imem_req, imem_addr, waited);
    end
  endtask

  task automatic test_jalr_branch();
    idle_in(); mem_lat = 1;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) cyc();
    cyc();
    JE = 2'b10; ALUResultE = 32'h203;
    cyc();
    idle_in();
    n_chk++;
    if ({PCF, ValidD} !== {32'h202, 1'b0}) begin
      n_err++; $display("FAIL jalr_target: got pcf=%h v=%b want 202/0", PCF, ValidD);
    end
    BranchE = 1; ZeroE = 0; PCE = 32'h40; ImmExtE = 32'h8;
    cyc();
    n_chk++;
    if ({PCF, InstrD, PCD, ValidD} !== {exp_pc, exp_instr, exp_pcd, exp_valid} || PCF === 32'h48) begin
      n_err++; $display("FAIL branch_not_taken: got pcf=%h pcd=%h v=%b want pcf=%h", PCF, PCD, ValidD, exp_pc);
    end
    ZeroE = 1;
    cyc();
    idle_in();
    n_chk++;
    if ({PCF, ValidD, InstrD} !== {32'h48, 1'b0, NOP}) begin
      n_err++; $display("FAIL branch_taken: got pcf=%h v=%b instr=%h want 48/0/%h", PCF, ValidD, InstrD, NOP);
    end
  endtask

  task automatic test_simultaneous();
    idle_in(); mem_lat = 1;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) cyc();
    cyc();
    BranchE = 1; ZeroE = 1; PCE = 32'h300; ImmExtE = 32'h24; StallD = 1;
    cyc();
    idle_in();
    n_chk++;
    if ({PCF, ValidD, InstrD, imem_req, imem_addr} !== {32'h324, 1'b0, NOP, 1'b1, 32'h324}) begin
      n_err++; $display("FAIL simultaneous: got pcf=%h v=%b instr=%h req=%b addr=%h want 324/0/%h/1/324", PCF, ValidD, InstrD, imem_req, imem_addr, NOP);
    end
  endtask

  task automatic test_reset_mid();
    idle_in(); mem_lat = 2;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) cyc();
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    n_chk++;
    if ({PCF, imem_req, InstrD, PCD, PCPlus4D, ValidD} !== {32'h0, 1'b0, NOP, 32'h0, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL reset_mid_values: got pcf=%h req=%b instr=%h pcd=%h pc4=%h v=%b", PCF, imem_req, InstrD, PCD, PCPlus4D, ValidD);
    end
    mem_lat = 1;
    cyc();
    n_chk++;
    if ({imem_req, imem_addr, ValidD} !== {1'b1, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL reset_late_valid: got req=%b addr=%h v=%b want 1/0/0", imem_req, imem_addr, ValidD);
    end
    cyc(); cyc();
    n_chk++;
    if ({ValidD, InstrD, PCD, PCF} !== {1'b1, mem_word(32'h0), 32'h0, 32'h4}) begin
      n_err++; $display("FAIL reset_mid_refetch: got v=%b instr=%h pcd=%h pcf=%h", ValidD, InstrD, PCD, PCF);
    end
  endtask

  task automatic test_wrap();
    idle_in(); mem_lat = 1;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) cyc();
    cyc();
    JE = 2'b10; ALUResultE = 32'hFFFF_FFFD;
    cyc();
    idle_in();
    n_chk++;
    if (PCF !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_target: got pcf=%h want fffffffc", PCF); end
    cyc(); cyc();
    n_chk++;
    if ({PCF, PCD, PCPlus4D, InstrD, ValidD} !== {32'h0, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC), 1'b1}) begin
      n_err++; $display("FAIL wrap: got pcf=%h pcd=%h pc4=%h instr=%h v=%b want 0/fffffffc/0/%h/1", PCF, PCD, PCPlus4D, InstrD, ValidD, mem_word(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_random();
    int acc0, r;
    acc0 = accepted;
    for (int i = 0; i < 400; i++) begin
      idle_in();
      StallD  = ($urandom_range(0, 3) == 0);
      mem_lat = $urandom_range(1, 3);
      PCE = $urandom & 32'hFFFC; ImmExtE = $urandom & 32'h3FC; ALUResultE = $urandom;
      r = $urandom_range(0, 15);
      case (r)
        0: JE = 2'b01;
        1: JE = 2'b10;
        2: begin BranchE = 1; ZeroE = $urandom_range(0, 1); end
        3: JE = 2'b11;
        default: ;
      endcase
      cyc();
      n_chk++;
      if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== {exp_pc, exp_instr, exp_pcd, exp_pc4, exp_valid}) begin
        n_err++; $display("FAIL random c%0d: got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b", cyc_n, PCF, InstrD, PCD, PCPlus4D, ValidD, exp_pc, exp_instr, exp_pcd, exp_pc4, exp_valid);
      end
    end
    idle_in();
    n_chk++;
    if (req_bad !== 0) begin n_err++; $display("FAIL request_protocol: got %0d bad requests want 0", req_bad); end
    n_chk++;
    if (accepted - acc0 < 20) begin n_err++; $display("FAIL random_progress: got %0d instructions want >=20", accepted - acc0); end
  endtask

  initial begin
    rst = 1; idle_in(); imem_valid = 0; imem_rdata = 0;
    exp_pc = 0; exp_instr = NOP; exp_pcd = 0; exp_pc4 = 0; exp_valid = 0;
    held = 0; held_word = 0;
    @(posedge clk); #1;
    test_reset();
    test_straight();
    test_stall();
    test_jal();
    test_jalr_branch();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
